// File: rtl/ila_dump_ctrl.sv
// Readout sequencer: walks the circular ILA capture buffer and streams a framed
// byte sequence (header, sample bytes MSB first, checksum) to a UART transmitter.
module ila_dump_ctrl #(
    parameter int          SAMPLE_WIDTH = 32,
    parameter int          DEPTH_LOG2   = 10,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic                    i_sys_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [DEPTH_LOG2-1:0]   i_start_addr,
    output logic [DEPTH_LOG2-1:0]   o_rd_addr,
    output logic                    o_rd_en,
    input  logic [SAMPLE_WIDTH-1:0] i_rd_data,
    output logic                    o_Tx_DV,
    output logic [7:0]              o_Tx_Byte,
    input  logic                    i_Tx_Done,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int BYTES = SAMPLE_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [DEPTH_LOG2:0] ALL_SAMPLES = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_HI, WAIT_LO, READ, LATCH, CHECK, FINISH
    } state_t;

    // Which part of the frame the byte in flight belongs to.
    typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CHK} phase_t;

    state_t                  state, state_d;
    phase_t                  phase, phase_d;
    logic [DEPTH_LOG2-1:0]   addr, addr_d;
    logic [DEPTH_LOG2:0]     sample_cnt, sample_cnt_d;
    logic [IDX_W-1:0]        byte_idx, byte_idx_d;
    logic [SAMPLE_WIDTH-1:0] sample, sample_d;
    logic [SAMPLE_WIDTH-1:0] sample_shl;
    logic [7:0]              checksum, checksum_d;
    logic [7:0]              tx_byte, tx_byte_d;

    assign sample_shl = sample << 8;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            phase      <= PH_HDR;
            addr       <= '0;
            sample_cnt <= '0;
            byte_idx   <= '0;
            sample     <= '0;
            checksum   <= '0;
            tx_byte    <= '0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            addr       <= addr_d;
            sample_cnt <= sample_cnt_d;
            byte_idx   <= byte_idx_d;
            sample     <= sample_d;
            checksum   <= checksum_d;
            tx_byte    <= tx_byte_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d      = state;
        phase_d      = phase;
        addr_d       = addr;
        sample_cnt_d = sample_cnt;
        byte_idx_d   = byte_idx;
        sample_d     = sample;
        checksum_d   = checksum;
        tx_byte_d    = tx_byte;

        case (state)
            IDLE: begin
                if (i_start) begin
                    addr_d       = i_start_addr;
                    sample_cnt_d = '0;
                    byte_idx_d   = '0;
                    checksum_d   = '0;
                    phase_d      = PH_HDR;
                    tx_byte_d    = HEADER_BYTE;
                    state_d      = SEND;
                end
            end
            SEND:    state_d = WAIT_HI;
            WAIT_HI: if (i_Tx_Done) state_d = WAIT_LO;
            WAIT_LO: begin
                if (!i_Tx_Done) begin
                    case (phase)
                        PH_HDR: begin
                            phase_d = PH_DATA;
                            state_d = READ;
                        end
                        PH_DATA: begin
                            if (byte_idx != LAST_IDX) begin
                                sample_d   = sample_shl;
                                tx_byte_d  = sample_shl[SAMPLE_WIDTH-1 -: 8];
                                checksum_d = checksum + sample_shl[SAMPLE_WIDTH-1 -: 8];
                                byte_idx_d = byte_idx + 1'b1;
                                state_d    = SEND;
                            end else if (sample_cnt == ALL_SAMPLES) begin
                                tx_byte_d = checksum;
                                phase_d   = PH_CHK;
                                state_d   = CHECK;
                            end else begin
                                addr_d  = addr + 1'b1;
                                state_d = READ;
                            end
                        end
                        default: state_d = FINISH;
                    endcase
                end
            end
            READ:  state_d = LATCH;
            // Read data arrives exactly one cycle after the READ strobe.
            LATCH: begin
                sample_d     = i_rd_data;
                tx_byte_d    = i_rd_data[SAMPLE_WIDTH-1 -: 8];
                checksum_d   = checksum + i_rd_data[SAMPLE_WIDTH-1 -: 8];
                byte_idx_d   = '0;
                sample_cnt_d = sample_cnt + 1'b1;
                state_d      = SEND;
            end
            CHECK:  state_d = WAIT_HI;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_rd_addr = addr;
    assign o_rd_en   = (state == READ);
    assign o_Tx_DV   = (state == SEND) || (state == CHECK);
    assign o_Tx_Byte = tx_byte;
    assign o_busy    = (state != IDLE) && (state != FINISH);
    assign o_done    = (state == FINISH);

endmodule

// File: tb/tb_ila_dump_ctrl.sv
// Self-checking bench for ila_dump_ctrl: RAM and UART transmitter models plus a
// frame-level reference model built from the buffer contents and start address.
module tb_ila_dump_ctrl;

    localparam int         SW    = 16;
    localparam int         DL2   = 2;
    localparam int         DEPTH = 4;
    localparam int         BYTES = SW / 8;
    localparam logic [7:0] HDR   = 8'hA5;
    localparam int         LIMIT = 3000;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [DL2-1:0] start_addr;
    logic [DL2-1:0] rd_addr;
    logic           rd_en;
    logic [SW-1:0]  rd_data = '0;
    logic           tx_dv;
    logic [7:0]     tx_byte;
    logic           tx_done;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    ila_dump_ctrl #(
        .SAMPLE_WIDTH (SW),
        .DEPTH_LOG2   (DL2),
        .HEADER_BYTE  (HDR)
    ) dut (
        .i_sys_clk    (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_start_addr (start_addr),
        .o_rd_addr    (rd_addr),
        .o_rd_en      (rd_en),
        .i_rd_data    (rd_data),
        .o_Tx_DV      (tx_dv),
        .o_Tx_Byte    (tx_byte),
        .i_Tx_Done    (tx_done),
        .o_busy       (busy),
        .o_done       (done)
    );

    // Capture RAM: registered read, data valid one cycle after the strobe.
    logic [SW-1:0] mem [DEPTH];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0]     got_bytes [$];
    logic [DL2-1:0] got_addrs [$];
    logic [7:0]     exp_bytes [$];
    logic [DL2-1:0] exp_addrs [$];
    int done_cnt = 0;
    int tx_delay = 10;
    int tx_hold  = 2;
    int dly_cnt  = 0;
    int hold_cnt = 0;

    // Monitor and transmitter model share one process so observation happens
    // before the model updates i_Tx_Done on the same falling edge.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                dly_cnt  = 0;
                hold_cnt = 0;
                tx_done  = 1'b0;
            end else begin
                if (tx_dv) begin
                    got_bytes.push_back(tx_byte);
                    check("dv_while_done", tx_done, 0);
                    dly_cnt = tx_delay;
                end else if (dly_cnt > 0) begin
                    dly_cnt--;
                    if (dly_cnt == 0) hold_cnt = tx_hold;
                end
                if (rd_en) got_addrs.push_back(rd_addr);
                if (done) begin
                    done_cnt++;
                    check("busy_at_done", busy, 0);
                end
                tx_done = (hold_cnt > 0);
                if (hold_cnt > 0) hold_cnt--;
            end
        end
    end

    task automatic build_exp(input int sa);
        int sum;
        int a;
        logic [SW-1:0] w;
        logic [7:0] bt;
        exp_bytes.delete();
        exp_addrs.delete();
        exp_bytes.push_back(HDR);
        sum = 0;
        for (int s = 0; s < DEPTH; s++) begin
            a = (sa + s) % DEPTH;
            exp_addrs.push_back(a[DL2-1:0]);
            for (int b = 0; b < BYTES; b++) begin
                w  = mem[a] >> (8 * (BYTES - 1 - b));
                bt = w[7:0];
                exp_bytes.push_back(bt);
                sum += int'(bt);
            end
        end
        exp_bytes.push_back(8'(sum % 256));
    endtask

    task automatic run_frame(input int sa, input int restart_at);
        int bb, ab, db, cyc;
        bb = got_bytes.size();
        ab = got_addrs.size();
        db = done_cnt;
        build_exp(sa);
        start_addr = DL2'(sa);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_addr = DL2'($urandom_range(0, DEPTH - 1));
        check("busy_after_start", busy, 1);
        cyc = 0;
        while (done_cnt == db && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            start      = (cyc == restart_at);
            start_addr = DL2'($urandom_range(0, DEPTH - 1));
        end
        start = 1'b0;
        check("frame_timeout", (cyc < LIMIT), 1);
        repeat (4) @(negedge clk);
        check("done_count", done_cnt - db, 1);
        check("busy_after", busy, 0);
        check("byte_count", got_bytes.size() - bb, exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            if (bb + i < got_bytes.size()) check("byte", got_bytes[bb + i], exp_bytes[i]);
        check("rd_count", got_addrs.size() - ab, exp_addrs.size());
        for (int i = 0; i < exp_addrs.size(); i++)
            if (ab + i < got_addrs.size()) check("rd_addr", got_addrs[ab + i], exp_addrs[i]);
    endtask

    initial begin
        int cyc, bb;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_tx_dv", tx_dv, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame from address 0.
        mem[0] = 16'h1122; mem[1] = 16'h3344; mem[2] = 16'h5566; mem[3] = 16'h7788;
        tx_delay = 10; tx_hold = 2;
        run_frame(0, -1);
        check("cksum_0x64", got_bytes[got_bytes.size() - 1], 8'h64);

        // Wrapped start address with a stray start pulse mid-frame.
        run_frame(3, 40);

        // Transmitter holds done high for several cycles.
        tx_delay = 3; tx_hold = 5;
        run_frame(1, -1);

        // Asynchronous reset after the 4th byte, then a fresh frame.
        tx_delay = 6; tx_hold = 2;
        bb = got_bytes.size();
        start_addr = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (got_bytes.size() - bb < 4 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_wait_timeout", (cyc < LIMIT), 1);
        #3 rst = 1'b1;
        #1;
        check("arst_tx_dv", tx_dv, 0);
        check("arst_rd_en", rd_en, 0);
        check("arst_busy", busy, 0);
        check("arst_tx_byte", tx_byte, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(2, -1);

        // All-ones buffer starting at 2.
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hFFFF;
        tx_delay = 2; tx_hold = 1;
        run_frame(2, -1);
        check("cksum_0xf8", got_bytes[got_bytes.size() - 1], 8'hF8);

        // Randomised buffers, start addresses and transmitter timing.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = SW'($urandom);
            tx_delay = $urandom_range(1, 12);
            tx_hold  = $urandom_range(1, 6);
            run_frame($urandom_range(0, DEPTH - 1), (k == 2) ? 25 : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
